// File: rtl/id_decode_stage_pkg.sv
// Shared decode header: instruction-bus ordering, width and MIPS
// opcode/funct/REGIMM-rt encodings used by every pipeline stage.
package id_decode_stage_pkg;

  // Bit positions on the one-hot instruction bus (the ALU relies on this order).
  typedef enum logic [5:0] {
    I_ADD, I_ADDU, I_ADDI, I_ADDIU, I_SUB, I_SUBU,
    I_LW, I_LWL, I_LWR, I_LB, I_LBU, I_LH, I_LHU, I_SW, I_SWL, I_SWR, I_SB, I_SH,
    I_AND, I_OR, I_XOR, I_NOR, I_ANDI, I_ORI, I_XORI, I_LUI,
    I_SLL, I_SRL, I_SRA, I_SLLV, I_SRLV, I_SRAV,
    I_SLT, I_SLTU, I_SLTI, I_SLTIU,
    I_JAL, I_JALR, I_BLTZAL, I_BGEZAL,
    I_J, I_JR, I_BEQ, I_BNE, I_BLEZ, I_BGTZ, I_BLTZ, I_BGEZ
  } instr_idx_e;

  localparam int INSTRBUS_WIDTH = 48;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LWL     = 6'h22;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_LWR     = 6'h26;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SWL     = 6'h2A;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] OP_SWR     = 6'h2E;

  // SPECIAL funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // REGIMM rt selectors
  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  // One decoded pipeline entry as held by the skid and output registers.
  typedef struct packed {
    logic [INSTRBUS_WIDTH-1:0] instr_bus;
    logic                      ri;
    logic [15:0]               imm16;
    logic [4:0]                shamt;
    logic [4:0]                rs;
    logic [4:0]                rt;
    logic [4:0]                rd;
    logic [31:0]               pc;
  } dec_entry_t;

  // Build the one-hot bus value for a given instruction index.
  function automatic logic [INSTRBUS_WIDTH-1:0] onehot(input instr_idx_e idx);
    logic [INSTRBUS_WIDTH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/id_decode_stage_instr_decoder.sv
// Pure combinational MIPS word -> one-hot instruction bus + reserved flag.
// Fields not used for selection (e.g. rs on sll) are deliberately ignored.
module instr_decoder
  import id_decode_stage_pkg::*;
(
  input  logic [31:0]               instr,
  output logic [INSTRBUS_WIDTH-1:0] instr_bus,
  output logic                      ri
);

  logic [5:0] op_s;
  logic [5:0] funct_s;
  logic [4:0] rt_s;
  logic       hit_s;
  instr_idx_e idx_s;

  assign op_s    = instr[31:26];
  assign funct_s = instr[5:0];
  assign rt_s    = instr[20:16];

  // Select the instruction index; any unlisted encoding clears hit_s.
  always_comb begin
    hit_s = 1'b1;
    idx_s = I_SLL;
    case (op_s)
      OP_SPECIAL: begin
        case (funct_s)
          FN_SLL:  idx_s = I_SLL;
          FN_SRL:  idx_s = I_SRL;
          FN_SRA:  idx_s = I_SRA;
          FN_SLLV: idx_s = I_SLLV;
          FN_SRLV: idx_s = I_SRLV;
          FN_SRAV: idx_s = I_SRAV;
          FN_JR:   idx_s = I_JR;
          FN_JALR: idx_s = I_JALR;
          FN_ADD:  idx_s = I_ADD;
          FN_ADDU: idx_s = I_ADDU;
          FN_SUB:  idx_s = I_SUB;
          FN_SUBU: idx_s = I_SUBU;
          FN_AND:  idx_s = I_AND;
          FN_OR:   idx_s = I_OR;
          FN_XOR:  idx_s = I_XOR;
          FN_NOR:  idx_s = I_NOR;
          FN_SLT:  idx_s = I_SLT;
          FN_SLTU: idx_s = I_SLTU;
          default: hit_s = 1'b0;
        endcase
      end
      OP_REGIMM: begin
        case (rt_s)
          RT_BLTZ:   idx_s = I_BLTZ;
          RT_BGEZ:   idx_s = I_BGEZ;
          RT_BLTZAL: idx_s = I_BLTZAL;
          RT_BGEZAL: idx_s = I_BGEZAL;
          default:   hit_s = 1'b0;
        endcase
      end
      OP_J:     idx_s = I_J;
      OP_JAL:   idx_s = I_JAL;
      OP_BEQ:   idx_s = I_BEQ;
      OP_BNE:   idx_s = I_BNE;
      OP_BLEZ:  idx_s = I_BLEZ;
      OP_BGTZ:  idx_s = I_BGTZ;
      OP_ADDI:  idx_s = I_ADDI;
      OP_ADDIU: idx_s = I_ADDIU;
      OP_SLTI:  idx_s = I_SLTI;
      OP_SLTIU: idx_s = I_SLTIU;
      OP_ANDI:  idx_s = I_ANDI;
      OP_ORI:   idx_s = I_ORI;
      OP_XORI:  idx_s = I_XORI;
      OP_LUI:   idx_s = I_LUI;
      OP_LB:    idx_s = I_LB;
      OP_LH:    idx_s = I_LH;
      OP_LWL:   idx_s = I_LWL;
      OP_LW:    idx_s = I_LW;
      OP_LBU:   idx_s = I_LBU;
      OP_LHU:   idx_s = I_LHU;
      OP_LWR:   idx_s = I_LWR;
      OP_SB:    idx_s = I_SB;
      OP_SH:    idx_s = I_SH;
      OP_SWL:   idx_s = I_SWL;
      OP_SW:    idx_s = I_SW;
      OP_SWR:   idx_s = I_SWR;
      default:  hit_s = 1'b0;
    endcase
  end

  assign instr_bus = hit_s ? onehot(idx_s) : {INSTRBUS_WIDTH{1'b0}};
  assign ri        = ~hit_s;

endmodule

// File: rtl/id_decode_stage.sv
// Instruction-decode stage: decodes on the input side, then holds the result
// in an output register backed by a one-entry skid buffer so in_ready is a
// pure flop output, independent of out_ready.
module id_decode_stage
  import id_decode_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_instr,
  input  logic [31:0]               in_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [INSTRBUS_WIDTH-1:0] out_instr_bus,
  output logic [15:0]               out_imm16,
  output logic [4:0]                out_shamt,
  output logic [4:0]                out_rs,
  output logic [4:0]                out_rt,
  output logic [4:0]                out_rd,
  output logic [31:0]               out_pc,
  output logic                      out_ri
);

  localparam dec_entry_t RESET_ENTRY = '{
    instr_bus: {INSTRBUS_WIDTH{1'b0}},
    ri:        1'b0,
    imm16:     16'h0000,
    shamt:     5'd0,
    rs:        5'd0,
    rt:        5'd0,
    rd:        5'd0,
    pc:        RESET_PC
  };

  logic [INSTRBUS_WIDTH-1:0] dec_bus_s;
  logic                      dec_ri_s;
  dec_entry_t                in_entry_s;

  dec_entry_t out_q,  out_d;
  dec_entry_t skid_q, skid_d;
  logic       out_valid_q, out_valid_d;
  logic       skid_valid_q, skid_valid_d;
  logic       in_ready_q, in_ready_d;

  logic in_fire_s;
  logic out_load_s;

  instr_decoder u_instr_decoder (
    .instr     (in_instr),
    .instr_bus (dec_bus_s),
    .ri        (dec_ri_s)
  );

  // Pack the freshly decoded instruction into a pipeline entry.
  always_comb begin
    in_entry_s.instr_bus = dec_bus_s;
    in_entry_s.ri        = dec_ri_s;
    in_entry_s.imm16     = in_instr[15:0];
    in_entry_s.shamt     = in_instr[10:6];
    in_entry_s.rs        = in_instr[25:21];
    in_entry_s.rt        = in_instr[20:16];
    in_entry_s.rd        = in_instr[15:11];
    in_entry_s.pc        = in_pc;
  end

  // A flush-cycle input is never accepted; the output register may load
  // whenever it is empty or being drained this cycle.
  assign in_fire_s  = in_valid & in_ready_q & ~flush;
  assign out_load_s = ~out_valid_q | out_ready;

  // Next-state for the output register, skid buffer and in_ready.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_load_s) begin
      if (skid_valid_q) begin
        // Older skid entry goes first; in_ready was low so no input fires.
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire_s) begin
        out_d        = in_entry_s;
        out_valid_d  = 1'b1;
      end else begin
        out_valid_d  = 1'b0;
      end
    end else if (in_fire_s) begin
      // Output is stalled: park the new entry in the skid buffer.
      skid_d       = in_entry_s;
      skid_valid_d = 1'b1;
    end else begin
      skid_valid_d = skid_valid_q;
    end
    in_ready_d = ~skid_valid_d;
  end

  // Pipeline state registers with asynchronous reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_q        <= RESET_ENTRY;
      skid_q       <= RESET_ENTRY;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_instr_bus = out_q.instr_bus;
  assign out_ri        = out_q.ri;
  assign out_imm16     = out_q.imm16;
  assign out_shamt     = out_q.shamt;
  assign out_rs        = out_q.rs;
  assign out_rt        = out_q.rt;
  assign out_rd        = out_q.rd;
  assign out_pc        = out_q.pc;

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed, table-driven bench for id_decode_stage plus hand-written
// sequences for backpressure, flush and asynchronous reset.
module tb_id_decode_stage;
  import id_decode_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic                      clk;
  logic                      resetn;
  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic [31:0]               in_instr;
  logic [31:0]               in_pc;
  logic                      out_valid;
  logic                      out_ready;
  logic [INSTRBUS_WIDTH-1:0] out_instr_bus;
  logic [15:0]               out_imm16;
  logic [4:0]                out_shamt;
  logic [4:0]                out_rs;
  logic [4:0]                out_rt;
  logic [4:0]                out_rd;
  logic [31:0]               out_pc;
  logic                      out_ri;

  int tests_run;
  int tests_failed;

  id_decode_stage #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr_bus (out_instr_bus),
    .out_imm16     (out_imm16),
    .out_shamt     (out_shamt),
    .out_rs        (out_rs),
    .out_rt        (out_rt),
    .out_rd        (out_rd),
    .out_pc        (out_pc),
    .out_ri        (out_ri)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    int          bit_idx;   // -1 means reserved instruction
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the output register holds the given instruction, valid.
  task automatic chk_entry(input string tag, input logic [31:0] instr,
                           input logic [31:0] pc, input int bit_idx);
    logic [INSTRBUS_WIDTH-1:0] eb;
    eb = '0;
    if (bit_idx >= 0) eb[bit_idx] = 1'b1;
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_bus"},   {16'd0, out_instr_bus}, {16'd0, eb});
    chk({tag, "_ri"},    {63'd0, out_ri}, {63'd0, (bit_idx < 0)});
    chk({tag, "_imm16"}, {48'd0, out_imm16}, {48'd0, instr[15:0]});
    chk({tag, "_shamt"}, {59'd0, out_shamt}, {59'd0, instr[10:6]});
    chk({tag, "_rs"},    {59'd0, out_rs}, {59'd0, instr[25:21]});
    chk({tag, "_rt"},    {59'd0, out_rt}, {59'd0, instr[20:16]});
    chk({tag, "_rd"},    {59'd0, out_rd}, {59'd0, instr[15:11]});
    chk({tag, "_pc"},    {32'd0, out_pc}, {32'd0, pc});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    chk({tag, "_bus"}, {16'd0, out_instr_bus}, 64'd0);
    chk({tag, "_ri"}, {63'd0, out_ri}, 64'd0);
    chk({tag, "_imm16"}, {48'd0, out_imm16}, 64'd0);
    chk({tag, "_fields"}, {49'd0, out_shamt, out_rs, out_rt}, 64'd0);
    chk({tag, "_rd"}, {59'd0, out_rd}, 64'd0);
    chk({tag, "_pc"}, {32'd0, out_pc}, {32'd0, RST_PC});
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    vecs[0]  = '{32'h2408_0005, 32'hBFC0_0000, I_ADDIU};
    vecs[1]  = '{32'h3C01_1234, 32'hBFC0_0004, I_LUI};
    vecs[2]  = '{32'h0003_1100, 32'hBFC0_0008, I_SLL};
    vecs[3]  = '{32'h0080_F809, 32'hBFC0_000C, I_JALR};
    vecs[4]  = '{32'h0000_0000, 32'hBFC0_0010, I_SLL};
    vecs[5]  = '{32'h03E3_1100, 32'hBFC0_0014, I_SLL};
    vecs[6]  = '{32'h03E0_0008, 32'hBFC0_0018, I_JR};
    vecs[7]  = '{32'h0085_1020, 32'hBFC0_001C, I_ADD};
    vecs[8]  = '{32'h0085_1021, 32'hBFC0_0020, I_ADDU};
    vecs[9]  = '{32'h0085_1027, 32'hBFC0_0024, I_NOR};
    vecs[10] = '{32'h0085_102A, 32'hBFC0_0028, I_SLT};
    vecs[11] = '{32'h00A4_1006, 32'hBFC0_002C, I_SRLV};
    vecs[12] = '{32'h20A5_FFFF, 32'hBFC0_0030, I_ADDI};
    vecs[13] = '{32'h28A5_000A, 32'hBFC0_0034, I_SLTI};
    vecs[14] = '{32'h8C82_0004, 32'hBFC0_0038, I_LW};
    vecs[15] = '{32'hAC82_0004, 32'hBFC0_003C, I_SW};
    vecs[16] = '{32'h0411_0003, 32'hBFC0_0040, I_BGEZAL};
    vecs[17] = '{32'h0410_0003, 32'hBFC0_0044, I_BLTZAL};
    vecs[18] = '{32'h0401_0003, 32'hBFC0_0048, I_BGEZ};
    vecs[19] = '{32'h0C00_0010, 32'hBFC0_004C, I_JAL};
    vecs[20] = '{32'h1085_0003, 32'hBFC0_0050, I_BEQ};
    vecs[21] = '{32'hFC00_0000, 32'hBFC0_0054, -1};
    vecs[22] = '{32'h0000_003F, 32'hBFC0_0058, -1};
    vecs[23] = '{32'h0405_0000, 32'hBFC0_005C, -1};

    resetn    = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    #22;
    resetn = 1'b1;
    step();
    chk_reset_vals("reset");

    // Back-to-back stream with out_ready=1: one entry per cycle.
    for (int i = 0; i < NVEC; i++) begin
      drive(1'b1, vecs[i].instr, vecs[i].pc);
      step();
      chk_entry($sformatf("vec%0d", i), vecs[i].instr, vecs[i].pc, vecs[i].bit_idx);
      chk($sformatf("vec%0d_in_ready", i), {63'd0, in_ready}, 64'd1);
    end
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("stream_drain_valid", {63'd0, out_valid}, 64'd0);

    // Backpressure: A held, B in skid, C waits for in_ready.
    out_ready = 1'b0;
    drive(1'b1, 32'h2408_0005, 32'h0000_1000);      // A addiu
    step();
    chk_entry("bp_a0", 32'h2408_0005, 32'h0000_1000, I_ADDIU);
    chk("bp_a0_in_ready", {63'd0, in_ready}, 64'd1);
    drive(1'b1, 32'h3C01_1234, 32'h0000_1004);      // B lui
    step();
    chk_entry("bp_a1", 32'h2408_0005, 32'h0000_1000, I_ADDIU);
    chk("bp_skid_full_in_ready", {63'd0, in_ready}, 64'd0);
    drive(1'b1, 32'h0003_1100, 32'h0000_1008);      // C sll, not yet accepted
    step();
    chk_entry("bp_a2", 32'h2408_0005, 32'h0000_1000, I_ADDIU);
    chk("bp_hold_in_ready", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    step();
    chk_entry("bp_b", 32'h3C01_1234, 32'h0000_1004, I_LUI);
    chk("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
    step();
    chk_entry("bp_c", 32'h0003_1100, 32'h0000_1008, I_SLL);
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("bp_end_valid", {63'd0, out_valid}, 64'd0);

    // Flush with output and skid full and a new input presented.
    out_ready = 1'b0;
    drive(1'b1, 32'h0085_1020, 32'h0000_2000);
    step();
    drive(1'b1, 32'h0085_1021, 32'h0000_2004);
    step();
    chk("fl_pre_in_ready", {63'd0, in_ready}, 64'd0);
    flush = 1'b1;
    drive(1'b1, 32'h0085_1027, 32'h0000_2008);
    step();
    chk("fl_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_in_ready", {63'd0, in_ready}, 64'd1);
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'h0C00_0010, 32'h0000_200C);
    step();
    chk_entry("fl_next", 32'h0C00_0010, 32'h0000_200C, I_JAL);
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("fl_nothing_left", {63'd0, out_valid}, 64'd0);

    // Flush with an empty stage: the flush-cycle input must be dropped.
    flush = 1'b1;
    drive(1'b1, 32'h1085_0003, 32'h0000_2010);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("fl_drop_input", {63'd0, out_valid}, 64'd0);
    step();
    chk("fl_drop_input2", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset between edges with output and skid full.
    out_ready = 1'b0;
    drive(1'b1, 32'hFC00_0000, 32'h0000_3000);
    step();
    drive(1'b1, 32'h03E3_1100, 32'h0000_3004);
    step();
    chk("ar_pre_ri", {63'd0, out_ri}, 64'd1);
    #3;
    resetn = 1'b0;
    #1;
    chk_reset_vals("ar_async");
    drive(1'b0, 32'h0, 32'h0);
    #2;
    resetn = 1'b1;
    step();
    chk_reset_vals("ar_after");
    out_ready = 1'b1;
    drive(1'b1, 32'h0401_0003, 32'h0000_3008);
    step();
    chk_entry("ar_resume", 32'h0401_0003, 32'h0000_3008, I_BGEZ);
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("ar_no_survivor", {63'd0, out_valid}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
